fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage between the program counter and decode. Issues in-order instruction-memory requests at the current PC, tracks outstanding responses, buffers returned instructions with their PCs in a small FIFO, and hands them to decode over a valid/ready handshake. Drives the PC block's enable and flushes all in-flight work on a control-flow redirect.

## Interface

Parameters:
- FIFO_DEPTH, 2: instruction buffer entries (power of two, ≥2).
- MAX_OUTSTANDING, 2: max granted-but-unanswered requests (≤ FIFO_DEPTH).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- pc  in  64 (`DWORD_BITS)  current PC from PC block.
- redirect  in  1  PC mode is not sequential this cycle (branch/jump taken).
- pc_en  out  1  PC block enable.
- imem_req  out  1  memory request valid.
- imem_addr  out  64  request address, equals pc.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid, in request order.
- imem_rdata  in  32 (`WORD_BITS)  instruction word.
- id_valid  out  1  decode entry valid.
- id_ready  in  1  decode accepts entry.
- id_instr  out  32  instruction at FIFO head.
- id_pc  out  64  PC of that instruction.

## Operation

- State: inflight PC queue (depth MAX_OUTSTANDING), outstanding count `osd`, drop count `drop`, output FIFO (count `cnt`, {pc, instr} entries).
- imem_req = !redirect && osd < MAX_OUTSTANDING && (cnt + osd) < FIFO_DEPTH, all terms from registered state.
- Issue: imem_req && imem_gnt → push pc into inflight queue, osd+1.
- pc_en = (imem_req && imem_gnt) || redirect; combinational.
- Response: imem_rvalid pops inflight queue, osd−1. If drop > 0: discard, drop−1. Else push {popped pc, imem_rdata} into output FIFO.
- imem_rvalid with osd == 0: ignored (stale, e.g. after reset).
- Output: id_valid = cnt != 0; id_pc/id_instr = head entry; pop on id_valid && id_ready.
- Redirect: FIFO cleared (cnt ← 0), inflight queue cleared, drop ← osd − (imem_rvalid ? 1 : 0) + existing drop handled so every still-pending response is discarded; osd tracks them until returned. No request issued in redirect cycle.
- Credits freed by a decode pop become usable the following cycle (no same-cycle bypass).
- Arithmetic: counters sized clog2(depth)+1, never wrap; queue pointers wrap modulo depth.

## Timing

- Reset: id_valid 0, imem_req 0, pc_en 0, cnt/osd/drop 0, FIFO contents don't-care; id_pc/id_instr 0.
- Request to decode: gnt cycle N, rvalid earliest N+1, id_valid high N+2 (FIFO registered).
- Steady state with 1-cycle memory and id_ready=1: one instruction per cycle.
- Redirect in cycle N: pc_en=1 in N; new target visible on pc in N+1; first request at target N+1.
- Redirect concurrent with rvalid: that response dropped. Concurrent with id pop: FIFO still cleared, popped entry counts as consumed.
- Reset asserted mid-operation: all state cleared immediately; late responses ignored via osd==0 rule.

## Configuration

- FETCH_STALL_CNT_EN defined: adds output stall_cnt (32 bits), reset 0, +1 each cycle id_ready && !id_valid, saturates at all-ones, cleared by reset only.
- Undefined: port and counter absent; behaviour otherwise identical.

## Test plan

- Reset, pc=0x1000, gnt=1, 1-cycle rvalid, id_ready=1 → id_pc 0x1000,0x1004,0x1008 on consecutive cycles, first id_valid 2 cycles after first gnt.
- id_ready=0, FIFO_DEPTH=2 → exactly 2 grants, then imem_req=0, pc_en=0; raise id_ready → requests resume next cycle.
- Two requests outstanding (0x2000,0x2004), redirect to 0x3000 → both responses dropped, next id_pc 0x3000.
- Redirect same cycle as rvalid and id pop → no entry from that response reaches decode; cnt=0 next cycle.
- imem_rvalid with osd=0 after reset → id_valid stays 0, osd stays 0.
- FETCH_STALL_CNT_EN, id_ready=1, gnt=0 for 10 cycles → stall_cnt=10.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch with outstanding-request tracking and a decode FIFO.
// Optional FETCH_STALL_CNT_EN adds a saturating decode-starvation counter (stall_cnt).
`ifndef DWORD_BITS
`define DWORD_BITS 64
`endif
`ifndef WORD_BITS
`define WORD_BITS 32
`endif

module fetch_unit #(
    parameter int FIFO_DEPTH      = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [`DWORD_BITS-1:0] pc,
    input  logic                   redirect,
    output logic                   pc_en,
    output logic                   imem_req,
    output logic [`DWORD_BITS-1:0] imem_addr,
    input  logic                   imem_gnt,
    input  logic                   imem_rvalid,
    input  logic [`WORD_BITS-1:0]  imem_rdata,
    output logic                   id_valid,
    input  logic                   id_ready,
    output logic [`WORD_BITS-1:0]  id_instr,
    output logic [`DWORD_BITS-1:0] id_pc
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0]            stall_cnt
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [QW-1:0] QLAST = QW'(MAX_OUTSTANDING - 1);

    logic [CW-1:0] cnt, osd, drop;
    logic [FW-1:0] head, tail;
    logic [QW-1:0] q_rd, q_wr;
    logic [`DWORD_BITS-1:0] q_pc [MAX_OUTSTANDING];
    logic [`DWORD_BITS-1:0] f_pc [FIFO_DEPTH];
    logic [`WORD_BITS-1:0]  f_instr [FIFO_DEPTH];
    logic issue, rsp, keep, push, pop;

    always_comb begin
        imem_req  = rst_n && !redirect && (osd < CW'(MAX_OUTSTANDING)) &&
                    (({1'b0, cnt} + {1'b0, osd}) < (CW+1)'(FIFO_DEPTH));
        issue     = imem_req && imem_gnt;
        pc_en     = rst_n && (issue || redirect);
        imem_addr = pc;
        rsp       = imem_rvalid && (osd != '0);
        keep      = rsp && (drop == '0);
        push      = keep && !redirect;
        id_valid  = cnt != '0;
        pop       = id_valid && id_ready;
        id_pc     = f_pc[head];
        id_instr  = f_instr[head];
    end

    // The inflight queue only holds requests whose responses will be kept;
    // dropped responses are accounted for by drop alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            osd  <= '0;
            drop <= '0;
            cnt  <= '0;
            head <= '0;
            tail <= '0;
            q_rd <= '0;
            q_wr <= '0;
        end else begin
            osd <= osd + CW'(issue) - CW'(rsp);
            if (redirect) begin
                drop <= osd - CW'(rsp);
                cnt  <= '0;
                head <= '0;
                tail <= '0;
                q_rd <= '0;
                q_wr <= '0;
            end else begin
                drop <= drop - CW'(rsp && (drop != '0));
                cnt  <= cnt + CW'(push) - CW'(pop);
                head <= pop ? head + FW'(1) : head;
                tail <= push ? tail + FW'(1) : tail;
                q_rd <= keep ? ((q_rd == QLAST) ? '0 : q_rd + QW'(1)) : q_rd;
                q_wr <= issue ? ((q_wr == QLAST) ? '0 : q_wr + QW'(1)) : q_wr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                f_pc[i]    <= '0;
                f_instr[i] <= '0;
            end
            for (int i = 0; i < MAX_OUTSTANDING; i++) q_pc[i] <= '0;
        end else begin
            if (issue) q_pc[q_wr] <= pc;
            if (push) begin
                f_pc[tail]    <= q_pc[q_rd];
                f_instr[tail] <= imem_rdata;
            end
        end
    end

`ifdef FETCH_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt <= '0;
        else if (id_ready && !id_valid && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table plus randomized run against a queue-based fetch model.
module tb_fetch_unit;
    localparam int FD = 2;
    localparam int MO = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] pc = 64'h1000;
    logic        redirect = 1'b0, pc_en, imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
    logic [63:0] imem_addr, id_pc;
    logic [31:0] imem_rdata = '0, id_instr;
    logic        id_valid, id_ready = 1'b0;
`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    fetch_unit #(.FIFO_DEPTH(FD), .MAX_OUTSTANDING(MO)) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .redirect(redirect), .pc_en(pc_en),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .id_valid(id_valid),
        .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc)
`ifdef FETCH_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  in;
        logic [63:0] tgt;
        logic [2:0]  ex;
        logic [63:0] ipc;
    } vec_t;
    typedef struct {
        logic [63:0] pc;
        logic        keep;
    } pend_t;
    typedef struct {
        logic [63:0] pc;
        logic [31:0] ins;
    } ent_t;

    int          total = 0, bad = 0;
    logic [63:0] mem_q[$];
    logic [63:0] target = '0;
    vec_t        tab[$];
    pend_t       pend[$];
    ent_t        fifo[$];

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9bdf;
    endfunction

    function automatic vec_t mk(input logic [3:0] i, input logic [63:0] t,
                                input logic [2:0] e, input logic [63:0] p);
        vec_t v;
        v.in = i; v.tgt = t; v.ex = e; v.ipc = p;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic rd, input logic g, input logic rv, input logic rdy);
        redirect    = rd;
        imem_gnt    = g;
        imem_rvalid = rv;
        id_ready    = rdy;
        imem_rdata  = (mem_q.size() != 0) ? instr_of(mem_q[0]) : 32'hdead_beef;
        #1;
    endtask

    // Memory and PC block: in-order responses, PC advances on pc_en.
    task automatic tick();
        logic iss, en, rd, rv;
        iss = imem_req && imem_gnt;
        en  = pc_en;
        rd  = redirect;
        rv  = imem_rvalid;
        @(posedge clk);
        #1;
        if (rv && mem_q.size() != 0) void'(mem_q.pop_front());
        if (iss) mem_q.push_back(pc);
        if (en) pc = rd ? target : pc + 64'd4;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        redirect = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; id_ready = 1'b0;
        mem_q.delete();
        #2;
        chk("rst_id_valid", 64'(id_valid), 64'd0);
        chk("rst_imem_req", 64'(imem_req), 64'd0);
        chk("rst_pc_en", 64'(pc_en), 64'd0);
        chk("rst_id_pc", id_pc, 64'd0);
        chk("rst_id_instr", 64'(id_instr), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // {redirect,gnt,rvalid,ready}, target, {req,pc_en,valid}, id_pc
        tab.push_back(mk(4'b0011, 64'h0, 3'b100, 64'h0));
        tab.push_back(mk(4'b0001, 64'h0, 3'b100, 64'h0));
        tab.push_back(mk(4'b0101, 64'h0, 3'b110, 64'h0));
        tab.push_back(mk(4'b0111, 64'h0, 3'b110, 64'h0));
        tab.push_back(mk(4'b0111, 64'h0, 3'b001, 64'h1000));
        tab.push_back(mk(4'b0101, 64'h0, 3'b111, 64'h1004));
        tab.push_back(mk(4'b0111, 64'h0, 3'b110, 64'h0));
        tab.push_back(mk(4'b0011, 64'h0, 3'b001, 64'h1008));
        tab.push_back(mk(4'b0001, 64'h0, 3'b101, 64'h100c));
        tab.push_back(mk(4'b0001, 64'h0, 3'b100, 64'h0));
        tab.push_back(mk(4'b0100, 64'h0, 3'b110, 64'h0));
        tab.push_back(mk(4'b0110, 64'h0, 3'b110, 64'h0));
        tab.push_back(mk(4'b0110, 64'h0, 3'b001, 64'h1010));
        tab.push_back(mk(4'b0100, 64'h0, 3'b001, 64'h1010));
        tab.push_back(mk(4'b0101, 64'h0, 3'b001, 64'h1010));
        tab.push_back(mk(4'b0101, 64'h0, 3'b111, 64'h1014));
        tab.push_back(mk(4'b0011, 64'h0, 3'b100, 64'h0));
        tab.push_back(mk(4'b0001, 64'h0, 3'b101, 64'h1018));
        tab.push_back(mk(4'b1000, 64'h2000, 3'b010, 64'h0));
        tab.push_back(mk(4'b0100, 64'h0, 3'b110, 64'h0));
        tab.push_back(mk(4'b0101, 64'h0, 3'b110, 64'h0));
        tab.push_back(mk(4'b1100, 64'h3000, 3'b010, 64'h0));
        tab.push_back(mk(4'b0011, 64'h0, 3'b000, 64'h0));
        tab.push_back(mk(4'b0011, 64'h0, 3'b100, 64'h0));
        tab.push_back(mk(4'b0101, 64'h0, 3'b110, 64'h0));
        tab.push_back(mk(4'b0011, 64'h0, 3'b100, 64'h0));
        tab.push_back(mk(4'b0001, 64'h0, 3'b101, 64'h3000));
        tab.push_back(mk(4'b0001, 64'h0, 3'b100, 64'h0));
        tab.push_back(mk(4'b0101, 64'h0, 3'b110, 64'h0));
        tab.push_back(mk(4'b0110, 64'h0, 3'b110, 64'h0));
        tab.push_back(mk(4'b1011, 64'h4000, 3'b011, 64'h3004));
        tab.push_back(mk(4'b0001, 64'h0, 3'b100, 64'h0));
        tab.push_back(mk(4'b0001, 64'h0, 3'b100, 64'h0));

        do_reset();
`ifdef FETCH_STALL_CNT_EN
        for (int i = 0; i < 10; i++) begin
            set_in(1'b0, 1'b0, 1'b0, 1'b1);
            tick();
        end
        chk("stall_cnt_10", 64'(stall_cnt), 64'd10);
`endif
        foreach (tab[k]) begin
            target = tab[k].tgt;
            set_in(tab[k].in[3], tab[k].in[2], tab[k].in[1], tab[k].in[0]);
            chk($sformatf("vec%0d_req", k), 64'(imem_req), 64'(tab[k].ex[2]));
            chk($sformatf("vec%0d_pc_en", k), 64'(pc_en), 64'(tab[k].ex[1]));
            chk($sformatf("vec%0d_valid", k), 64'(id_valid), 64'(tab[k].ex[0]));
            chk($sformatf("vec%0d_addr", k), imem_addr, pc);
            if (tab[k].ex[0]) begin
                chk($sformatf("vec%0d_id_pc", k), id_pc, tab[k].ipc);
                chk($sformatf("vec%0d_id_instr", k), 64'(id_instr), 64'(instr_of(tab[k].ipc)));
            end
            tick();
        end

        for (int i = 0; i < 3000; i++) begin
            logic rd, g, rv, rdy, er, iss, ev;
            pend_t p;
            ent_t  e;
            if (i == 1500) begin
                do_reset();
                pend.delete();
                fifo.delete();
            end
            rd     = $urandom_range(15) == 0;
            target = {32'h0, $urandom} & ~64'h3;
            g      = $urandom_range(3) != 0;
            rv     = (mem_q.size() != 0) ? ($urandom_range(2) != 0) : ($urandom_range(15) == 0);
            rdy    = $urandom_range(3) != 0;
            set_in(rd, g, rv, rdy);
            er  = !rd && pend.size() < MO && (fifo.size() + pend.size()) < FD;
            iss = er && g;
            ev  = fifo.size() != 0;
            chk("rnd_req", 64'(imem_req), 64'(er));
            chk("rnd_pc_en", 64'(pc_en), 64'(iss || rd));
            chk("rnd_valid", 64'(id_valid), 64'(ev));
            if (ev) begin
                chk("rnd_id_pc", id_pc, fifo[0].pc);
                chk("rnd_id_instr", 64'(id_instr), 64'(fifo[0].ins));
            end
            if (ev && rdy) void'(fifo.pop_front());
            if (rv && pend.size() != 0) begin
                p = pend.pop_front();
                if (p.keep && !rd) begin
                    e.pc  = p.pc;
                    e.ins = imem_rdata;
                    fifo.push_back(e);
                end
            end
            if (rd) begin
                fifo.delete();
                foreach (pend[k]) pend[k].keep = 1'b0;
            end
            if (iss) begin
                p.pc   = pc;
                p.keep = 1'b1;
                pend.push_back(p);
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
